// File: rtl/seven_seg_scan.sv
// Four-digit common-anode seven-segment scanner for a packed BCD value.
// The value is captured into a shadow register once per scan frame so a
// frame never mixes digits from two different input values. Supports
// leading-zero blanking, per-digit decimal points, a dash for non-BCD
// digits and whole-display blinking. All outputs are registered.
module seven_seg_scan #(
  parameter int REFRESH_DIV  = 100000,  // clk cycles per digit slot, >= 2
  parameter int BLINK_FRAMES = 64       // scan frames per blink half-period, >= 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic        blank_lz,
  input  logic        blink_en,
  input  logic [3:0]  dp_mask,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [DIV_W-1:0] div_cnt_reg;
  logic [1:0]       idx_reg;
  logic [15:0]      shadow_reg;
  logic [FRM_W-1:0] frame_cnt_reg;
  logic             blink_phase_reg;
  logic             first_load_reg;

  logic             tick;
  logic             wrap_load;
  logic             load;

  logic [3:0]       digit [4];
  logic [3:0]       upper_zero;
  logic [3:0]       cur_digit;
  logic             lz_blank;
  logic             off;
  logic [3:0]       an_next;
  logic [6:0]       seg_next;
  logic             dp_next;

  assign tick      = (div_cnt_reg == DIV_W'(REFRESH_DIV - 1));
  assign wrap_load = tick && (idx_reg == 2'd3);
  assign load      = wrap_load || first_load_reg;

  // Per-digit nibble and "this digit and everything above it is zero" flag.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      assign digit[gi]      = shadow_reg[4*gi +: 4];
      assign upper_zero[gi] = (shadow_reg[15:4*gi] == '0);
    end
  endgenerate

  assign cur_digit = digit[idx_reg];
  assign lz_blank  = blank_lz && (idx_reg != 2'd0) && upper_zero[idx_reg];
  assign off       = lz_blank || (blink_en && blink_phase_reg);

  // Digit-slot divider, scan index and frame-coherent shadow capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_reg    <= '0;
      idx_reg        <= 2'd0;
      shadow_reg     <= 16'h0000;
      first_load_reg <= 1'b1;
      frame_start    <= 1'b0;
    end else begin
      div_cnt_reg    <= tick ? '0 : div_cnt_reg + 1'b1;
      if (tick) begin
        idx_reg <= idx_reg + 2'd1;
      end
      first_load_reg <= 1'b0;
      if (load) begin
        shadow_reg <= data_in;
      end
      frame_start <= load;
    end
  end

  // Blink timing: counts completed frames; held cleared while blinking is off.
  always_ff @(posedge clk) begin
    if (reset || !blink_en) begin
      frame_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
    end else if (wrap_load) begin
      if (frame_cnt_reg == FRM_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_reg   <= '0;
        blink_phase_reg <= ~blink_phase_reg;
      end else begin
        frame_cnt_reg <= frame_cnt_reg + 1'b1;
      end
    end
  end

  // Segment decode (gfedcba, active-low), anode and decimal-point selection.
  always_comb begin
    seg_next = 7'b0111111;
    case (cur_digit)
      4'd0:    seg_next = 7'b1000000;
      4'd1:    seg_next = 7'b1111001;
      4'd2:    seg_next = 7'b0100100;
      4'd3:    seg_next = 7'b0110000;
      4'd4:    seg_next = 7'b0011001;
      4'd5:    seg_next = 7'b0010010;
      4'd6:    seg_next = 7'b0000010;
      4'd7:    seg_next = 7'b1111000;
      4'd8:    seg_next = 7'b0000000;
      4'd9:    seg_next = 7'b0010000;
      default: seg_next = 7'b0111111;
    endcase
    if (off) begin
      seg_next = 7'b1111111;
    end
    an_next = 4'b1111;
    if (!off) begin
      an_next[idx_reg] = 1'b0;
    end
    dp_next = ~(dp_mask[idx_reg] & ~off);
  end

  // Output register stage: display reflects last cycle's index and shadow.
  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
Downstream display stage for the 4-digit BCD up/down counter. Takes the counter's 16-bit packed BCD value (digit 0 = bits [3:0], rightmost) and time-multiplexes it onto a common-anode 4-digit seven-segment display.
- Latches the value once per scan frame so digits never tear.
- Supports leading-zero blanking, per-digit decimal points, invalid-digit dash display and whole-display blinking.

Parameters:
REFRESH_DIV, 100000, clk cycles per digit slot (100 MHz gives a 1 kHz digit rate); minimum 2
BLINK_FRAMES, 64, complete scan frames per blink half-period; minimum 1

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset on clk
data_in  in  16  packed BCD value, digit k = data_in[4k+3:4k]
blank_lz  in  1  1 = blank leading zero digits
blink_en  in  1  1 = blink whole display
dp_mask  in  4  bit k = 1 lights decimal point of digit k
an  out  4  anode enables, active-low, an[k] drives digit k
seg  out  7  segments, active-low, seg[6:0] = g,f,e,d,c,b,a
dp  out  1  decimal point, active-low
frame_start  out  1  one-cycle pulse on every shadow load

Behaviour:
- Reset values (applied on the edge where reset=1):
  - div_cnt=0, idx=0, shadow=0, frame_cnt=0, blink_phase=0
  - an=4'b1111, seg=7'b1111111, dp=1, frame_start=0
  - first_load flag set
- Divider: div_cnt counts 0..REFRESH_DIV-1 and wraps. tick=1 when div_cnt==REFRESH_DIV-1.
- Digit index: on tick, idx advances 0->1->2->3->0.
- Shadow load: shadow<=data_in and frame_start=1 on either of:
  - a tick where idx==3 (wrap to 0);
  - the first cycle with reset=0 while first_load=1; first_load clears on that cycle.
- data_in is sampled only at shadow load. Changes between loads are invisible until the next load.
- Blink counter: on each shadow load caused by an idx wrap, frame_cnt increments.
  - At BLINK_FRAMES-1, frame_cnt wraps to 0 and blink_phase toggles.
  - While blink_en=0, frame_cnt and blink_phase are held at 0.
- Outputs are registered, one cycle after idx/shadow; they reflect the idx and shadow of the previous cycle.
- Digit d = shadow[4idx+3:4idx].
- lz_blank(idx)=1 when blank_lz=1, idx!=0, and shadow digits idx..3 are all 0. Digit 0 is never LZ-blanked.
- off = lz_blank(idx) OR (blink_en AND blink_phase).
- an: all 1 except an[idx]=0 when off=0; when off=1, an=4'b1111.
- seg encoding for d (gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10..15 = 0111111 (dash)
  - off=1 forces seg=1111111.
- dp = ~(dp_mask[idx] & ~off).
- Simultaneous events:
  - reset has priority over tick and shadow load;
  - tick with idx==3 loads the shadow and moves idx to 0 on the same edge.
- Reset mid-frame: the outputs return to the all-off values listed above on the next edge; scanning restarts at digit 0 with a fresh shadow load.
- No combinational path exists from data_in to any output.

Test Plan:
1. REFRESH_DIV=4, reset, data_in=16'h1234, blank_lz=0 -> frame_start pulses 1 cycle after reset release; an cycles 1110/1101/1011/0111 with seg 0011001 / 0110000 / 0100100 / 1111001, each held 4 cycles.
2. blank_lz=1, data_in=16'h0045 -> an[3] and an[2] never 0; digit1 shows 0011001, digit0 shows 0010010. data_in=16'h0000 -> only an[0] ever 0, seg=1000000.
3. data_in=16'h9A3F -> digit0 and digit2 seg=0111111, digit1 seg=0110000, digit3 seg=0010000; blank_lz=1 does not blank digit 3.
4. Frame coherence: data_in changes 16'h1111 -> 16'h2222 while idx==1 -> digits 1..3 of the current frame still show 1; 2 appears only after the next frame_start.
5. BLINK_FRAMES=2, blink_en=1, dp_mask=4'b0100 -> an=1111 and dp=1 for frames 2-3, 6-7...; during visible frames dp=0 only while an=1011. blink_en=0 -> blinking stops immediately and the display is steady.
6. Reset asserted for 1 cycle while idx==2 -> next cycle an=1111, seg=1111111, dp=1; scan restarts at digit 0 with a new shadow load and a frame_start pulse.
